// File: rtl/morse_digit_player.sv
// Purpose : plays one BCD digit (0-9) as International Morse code on a single tone line.
// Latency : tone rises the cycle after start is accepted; done pulses T*UNIT_CYCLES cycles later.
// Backpressure: start is only accepted while busy=0; while busy it is ignored (no queueing).
//
// Ports:
//   clk      - system clock, all state on rising edge
//   reset    - synchronous, active-high; aborts playback with no done pulse
//   start    - playback request, sampled only when idle
//   digit    - BCD digit, latched on the accepting edge; >= 10 is rejected via err
//   tone     - 1 = mark (LED/buzzer on)
//   busy     - playback in progress (mark, space or trailing gap)
//   done     - one-cycle pulse in the first idle cycle after the trailing gap
//   err      - one-cycle pulse after a start with an invalid digit
//   sym_idx  - element being played (0..4), held at 4 during the gap, 0 when idle
module morse_digit_player #(
    parameter int UNIT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] digit,
    output logic       tone,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] sym_idx
);

    // One counter times every phase; the longest phase is 3 units.
    localparam int CW = $clog2(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] UNIT_LAST   = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] TRIPLE_LAST = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      dig_q, dig_nxt;
    logic [2:0]      idx_q, idx_nxt;
    logic            done_q, done_nxt;
    logic            err_q, err_nxt;
    logic [CW-1:0]   mark_last;

    // Element i of digit d is a dash?
    //   0     : all dashes
    //   1..5  : d dots then dashes
    //   6..9  : (d-5) dashes then dots
    function automatic logic is_dash(input logic [3:0] d, input logic [2:0] i);
        logic [3:0] iw;
        iw = {1'b0, i};
        if (d == 4'd0)
            return 1'b1;
        else if (d <= 4'd5)
            return (iw >= d);
        else
            return (iw < (d - 4'd5));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            dig_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dig_q  <= dig_nxt;
            idx_q  <= idx_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dig_nxt   = dig_q;
        idx_nxt   = idx_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        mark_last = is_dash(dig_q, idx_q) ? TRIPLE_LAST : UNIT_LAST;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (digit < 4'd10) begin
                        // Counter restarts here so units are phase-aligned to the start.
                        state_nxt = S_MARK;
                        dig_nxt   = digit;
                        idx_nxt   = 3'd0;
                        cnt_nxt   = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_MARK: begin
                if (cnt == mark_last) begin
                    cnt_nxt   = '0;
                    state_nxt = (idx_q == 3'd4) ? S_GAP : S_SPACE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_SPACE: begin
                if (cnt == UNIT_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx_q + 3'd1;
                    state_nxt = S_MARK;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == TRIPLE_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    // Outputs depend only on registered state, so they are glitch-free.
    assign tone    = (state == S_MARK);
    assign busy    = (state != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign sym_idx = idx_q;

endmodule

// File: tb/tb_morse_digit_player.sv
module tb_morse_digit_player;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] digit;
    logic       tone;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] sym_idx;

    int n_vec;
    int n_bad;

    morse_digit_player #(.UNIT_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .digit   (digit),
        .tone    (tone),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .sym_idx (sym_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {busy, tone, done, err, sym_idx}
    function automatic logic [6:0] obs();
        return {busy, tone, done, err, sym_idx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start playback of digit d at the current negedge and check every cycle
    // against hand-computed mark intervals [ms[i], me[i]] up to the done cycle.
    // Returns at the negedge of the done cycle. With poke=1, start pulses with
    // changing digits are driven while busy and must have no effect.
    task automatic play(input logic [3:0] d,
                        input logic [0:4][7:0] ms,
                        input logic [0:4][7:0] me,
                        input int done_cyc,
                        input bit poke);
        logic [6:0] e;
        int         k;
        bit         t;
        digit = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= done_cyc; c++) begin
            if (c < done_cyc) begin
                k = 0;
                t = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    if (c >= int'(ms[i])) k++;
                    if (c >= int'(ms[i]) && c <= int'(me[i])) t = 1'b1;
                end
                e = {1'b1, t, 1'b0, 1'b0, 3'(k - 1)};
            end else begin
                e = 7'b0010_000;
            end
            chk($sformatf("d%0d_c%0d", d, c), 32'(obs()), 32'(e));
            if (c < done_cyc) begin
                start = poke && (c % 7 == 3) && (c < done_cyc - 2);
                if (start) digit = 4'(c);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        digit = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(obs()), 32'h0);
        start = 1'b1;
        digit = 4'd3;
        @(negedge clk);
        chk("reset_wins", 32'(obs()), 32'h0);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", 32'(obs()), 32'h0);

        // digit 5: five dots, 12-cycle gap, done at 48
        play(4'd5, {8'd0, 8'd8, 8'd16, 8'd24, 8'd32},
                   {8'd3, 8'd11, 8'd19, 8'd27, 8'd35}, 48, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_after_5", 32'(obs()), 32'h0);

        // digit 1 with start pulses while busy: dot then four dashes, done at 80
        play(4'd1, {8'd0, 8'd8, 8'd24, 8'd40, 8'd56},
                   {8'd3, 8'd19, 8'd35, 8'd51, 8'd67}, 80, 1'b1);
        repeat (2) @(negedge clk);

        // digit 9 then digit 0 started in the done cycle (back-to-back)
        play(4'd9, {8'd0, 8'd16, 8'd32, 8'd48, 8'd64},
                   {8'd11, 8'd27, 8'd43, 8'd59, 8'd67}, 80, 1'b0);
        play(4'd0, {8'd0, 8'd16, 8'd32, 8'd48, 8'd64},
                   {8'd11, 8'd27, 8'd43, 8'd59, 8'd75}, 88, 1'b0);
        @(negedge clk);
        chk("idle_after_chain", 32'(obs()), 32'h0);

        // invalid digit: err for exactly one cycle, nothing else moves
        digit = 4'b1100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(obs()), 32'(7'b0001_000));
        @(negedge clk);
        chk("err_clear", 32'(obs()), 32'h0);
        repeat (3) @(negedge clk);
        chk("err_idle", 32'(obs()), 32'h0);

        // recovery after err: digit 2 = dot dot dash dash dash, done at 72
        play(4'd2, {8'd0, 8'd8, 8'd16, 8'd32, 8'd48},
                   {8'd3, 8'd11, 8'd27, 8'd43, 8'd59}, 72, 1'b0);
        repeat (2) @(negedge clk);

        // reset in cycle 6 of the first dash of digit 0
        digit = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort", 32'(obs()), 32'(7'b1100_000));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_zero", 32'(obs()), 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet_c%0d", c), 32'(obs()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
